// File: rtl/usb_reset_ctrl.sv
// Reset and USB line-state controller in front of the bootloader core.
// Holds core_reset until the PLL is stable, then watches D+/D- for a host bus reset or for suspend.
module usb_reset_ctrl #(
    parameter int POR_CYCLES        = 48000,
    parameter int SE0_RESET_CYCLES  = 120,
    parameter int RESET_HOLD_CYCLES = 48,
    parameter int SUSPEND_CYCLES    = 144000
) (
    input  logic clk_48mhz,
    input  logic reset,
    input  logic pll_lock,
    input  logic usb_p_rx,
    input  logic usb_n_rx,
    input  logic usb_tx_en,
    output logic core_reset,
    output logic bus_reset_pulse,
    output logic bus_reset,
    output logic suspend
);
    localparam int POR_W  = $clog2(POR_CYCLES + 1);
    localparam int SE0_W  = $clog2(SE0_RESET_CYCLES + 1);
    localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);
    localparam int IDLE_W = $clog2(SUSPEND_CYCLES + 1);

    localparam logic [POR_W-1:0]  POR_LAST  = POR_W'(POR_CYCLES - 1);
    localparam logic [POR_W-1:0]  POR_MAX   = POR_W'(POR_CYCLES);
    localparam logic [SE0_W-1:0]  SE0_LAST  = SE0_W'(SE0_RESET_CYCLES - 1);
    localparam logic [SE0_W-1:0]  SE0_MAX   = SE0_W'(SE0_RESET_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(RESET_HOLD_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(SUSPEND_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(SUSPEND_CYCLES);

    localparam logic [2:0] ST_POR_WAIT   = 3'd0;
    localparam logic [2:0] ST_RUN        = 3'd1;
    localparam logic [2:0] ST_BUS_RESET  = 3'd2;
    localparam logic [2:0] ST_RESET_HOLD = 3'd3;
    localparam logic [2:0] ST_SUSPEND    = 3'd4;

    logic lock_meta, lock_sync;
    logic p_meta, p_sync;
    logic n_meta, n_sync;

    logic [2:0]        state, state_next;
    logic [POR_W-1:0]  por_cnt, por_next;
    logic [SE0_W-1:0]  se0_cnt, se0_next;
    logic [HOLD_W-1:0] hold_cnt, hold_next;
    logic [IDLE_W-1:0] idle_cnt, idle_next;

    logic line_se0;
    logic line_idle;

    // Synchronizers reset to a locked-out PLL and an idle (J) bus
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
            p_meta    <= 1'b1;
            p_sync    <= 1'b1;
            n_meta    <= 1'b0;
            n_sync    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_sync <= lock_meta;
            p_meta    <= usb_p_rx;
            p_sync    <= p_meta;
            n_meta    <= usb_n_rx;
            n_sync    <= n_meta;
        end
    end

    // Our own transmissions look like J and never count towards reset or suspend
    assign line_se0  = !p_sync && !n_sync && !usb_tx_en;
    assign line_idle = p_sync && !n_sync && !usb_tx_en;

    always_comb begin
        state_next = state;
        por_next   = '0;
        se0_next   = '0;
        hold_next  = '0;
        idle_next  = '0;
        if (!lock_sync) begin
            state_next = ST_POR_WAIT;
        end else begin
            case (state)
                ST_POR_WAIT: begin
                    if (por_cnt == POR_LAST)
                        state_next = ST_RUN;
                    else
                        por_next = (por_cnt == POR_MAX) ? por_cnt : por_cnt + POR_W'(1);
                end
                ST_RUN: begin
                    if (line_se0 && se0_cnt == SE0_LAST) begin
                        state_next = ST_BUS_RESET;
                    end else if (line_idle && idle_cnt == IDLE_LAST) begin
                        state_next = ST_SUSPEND;
                    end else begin
                        if (line_se0)
                            se0_next = (se0_cnt == SE0_MAX) ? se0_cnt : se0_cnt + SE0_W'(1);
                        if (line_idle)
                            idle_next = (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + IDLE_W'(1);
                    end
                end
                ST_BUS_RESET: begin
                    if (!line_se0)
                        state_next = ST_RESET_HOLD;
                end
                ST_RESET_HOLD: begin
                    if (line_se0)
                        state_next = ST_BUS_RESET;
                    else if (hold_cnt == HOLD_LAST)
                        state_next = ST_RUN;
                    else
                        hold_next = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HOLD_W'(1);
                end
                ST_SUSPEND: begin
                    // An SE0 that wakes us counts as the first cycle of a possible bus reset
                    if (!line_idle) begin
                        state_next = ST_RUN;
                        se0_next   = line_se0 ? SE0_W'(1) : '0;
                    end
                end
                default: state_next = ST_POR_WAIT;
            endcase
        end
    end

    // core_reset lingers one extra cycle when leaving POR_WAIT
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            state           <= ST_POR_WAIT;
            por_cnt         <= '0;
            se0_cnt         <= '0;
            hold_cnt        <= '0;
            idle_cnt        <= '0;
            core_reset      <= 1'b1;
            bus_reset_pulse <= 1'b0;
            bus_reset       <= 1'b0;
            suspend         <= 1'b0;
        end else begin
            state           <= state_next;
            por_cnt         <= por_next;
            se0_cnt         <= se0_next;
            hold_cnt        <= hold_next;
            idle_cnt        <= idle_next;
            core_reset      <= (state == ST_POR_WAIT) ||
                               ((state_next != ST_RUN) && (state_next != ST_SUSPEND));
            bus_reset_pulse <= (state == ST_RUN) && (state_next == ST_BUS_RESET);
            bus_reset       <= (state_next == ST_BUS_RESET);
            suspend         <= (state_next == ST_SUSPEND);
        end
    end
endmodule
